hazard_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage processor. It sits beside the decode stage and the F/D, D/X and X/M pipeline registers, and generates their write-enables, flushes and bubbles. It handles three cases: taken-branch/jump redirects resolved in X, load-use hazards against the register pair decode is reading, and multi-cycle mult/div operations that must hold X until the multdiv unit answers. It also keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/hazard_stall_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: branch redirects, load-use stalls and
// multi-cycle mult/div holds for the F/D, D/X and X/M pipeline registers.
module hazard_stall_ctrl #(
    parameter int MD_TIMEOUT  = 64,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [4:0]             fd_rs1,
    input  logic [4:0]             fd_rs2,
    input  logic                   fd_uses_rs2,
    input  logic                   dx_is_load,
    input  logic [4:0]             dx_rd,
    input  logic                   x_redirect,
    input  logic                   x_md_start,
    input  logic                   md_ready,
    input  logic                   md_exception,
    input  logic                   stat_clear,
    output logic                   pc_we,
    output logic                   fd_we,
    output logic                   dx_we,
    output logic                   fd_flush,
    output logic                   dx_flush,
    output logic                   xm_bubble,
    output logic                   md_done,
    output logic                   md_fault,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int                WAIT_W    = $clog2(MD_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

    typedef enum logic {
        RUN,
        MD_WAIT
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              md_timeout;
    logic              md_release;

    // Register x0 is hardwired to zero, so a load targeting it never conflicts.
    assign load_use   = dx_is_load && (dx_rd != 5'd0) &&
                        ((dx_rd == fd_rs1) || (fd_uses_rs2 && (dx_rd == fd_rs2)));
    assign md_timeout = (wait_cnt == WAIT_LAST);
    assign md_release = md_ready || md_exception || md_timeout;

    always_comb begin
        pc_we     = 1'b0;
        fd_we     = 1'b0;
        dx_we     = 1'b0;
        fd_flush  = 1'b0;
        dx_flush  = 1'b0;
        xm_bubble = 1'b0;
        md_done   = 1'b0;
        md_fault  = 1'b0;
        if (reset_n) begin
            case (state)
                RUN: begin
                    if (x_redirect) begin
                        pc_we    = 1'b1;
                        fd_we    = 1'b1;
                        dx_we    = 1'b1;
                        fd_flush = 1'b1;
                        dx_flush = 1'b1;
                    end else if (x_md_start) begin
                        xm_bubble = 1'b1;
                    end else if (load_use) begin
                        dx_we    = 1'b1;
                        dx_flush = 1'b1;
                    end else begin
                        pc_we = 1'b1;
                        fd_we = 1'b1;
                        dx_we = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (md_release) begin
                        pc_we    = 1'b1;
                        fd_we    = 1'b1;
                        dx_we    = 1'b1;
                        md_done  = 1'b1;
                        md_fault = md_exception || md_timeout;
                    end else begin
                        xm_bubble = 1'b1;
                    end
                end
                default: begin
                    pc_we = 1'b1;
                    fd_we = 1'b1;
                    dx_we = 1'b1;
                end
            endcase
        end
    end

    // The wait counter stops at its last value rather than wrapping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (!x_redirect && x_md_start) begin
                        state    <= MD_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MD_WAIT: begin
                    if (md_release) begin
                        state <= RUN;
                    end else if (wait_cnt != WAIT_LAST) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (stat_clear) begin
            stall_count <= '0;
        end else if (!pc_we && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized and directed bench for hazard_stall_ctrl; two instances (default
// and small parameters) share stimulus and are compared to a cycle model.
module tb_hazard_stall_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [4:0] fd_rs1, fd_rs2, dx_rd;
    logic       fd_uses_rs2, dx_is_load, x_redirect, x_md_start;
    logic       md_ready, md_exception, stat_clear;

    wire [7:0]  ctl_a, ctl_b;
    wire [15:0] sc_a;
    wire [2:0]  sc_b;

    always #5 clock = ~clock;

    hazard_stall_ctrl #(.MD_TIMEOUT(64), .STALL_CNT_W(16)) dut_a (
        .clock(clock), .reset_n(reset_n), .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
        .fd_uses_rs2(fd_uses_rs2), .dx_is_load(dx_is_load), .dx_rd(dx_rd),
        .x_redirect(x_redirect), .x_md_start(x_md_start), .md_ready(md_ready),
        .md_exception(md_exception), .stat_clear(stat_clear),
        .pc_we(ctl_a[7]), .fd_we(ctl_a[6]), .dx_we(ctl_a[5]), .fd_flush(ctl_a[4]),
        .dx_flush(ctl_a[3]), .xm_bubble(ctl_a[2]), .md_done(ctl_a[1]),
        .md_fault(ctl_a[0]), .stall_count(sc_a)
    );

    hazard_stall_ctrl #(.MD_TIMEOUT(4), .STALL_CNT_W(3)) dut_b (
        .clock(clock), .reset_n(reset_n), .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
        .fd_uses_rs2(fd_uses_rs2), .dx_is_load(dx_is_load), .dx_rd(dx_rd),
        .x_redirect(x_redirect), .x_md_start(x_md_start), .md_ready(md_ready),
        .md_exception(md_exception), .stat_clear(stat_clear),
        .pc_we(ctl_b[7]), .fd_we(ctl_b[6]), .dx_we(ctl_b[5]), .fd_flush(ctl_b[4]),
        .dx_flush(ctl_b[3]), .xm_bubble(ctl_b[2]), .md_done(ctl_b[1]),
        .md_fault(ctl_b[0]), .stall_count(sc_b)
    );

    int checks = 0;
    int passes = 0;

    // Model state per instance: busy in mult/div, cycles since start, stall total.
    bit m_md[2];
    int m_el[2];
    int m_stall[2];

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    endtask

    function automatic int timeoutOf(input int i);
        return (i == 0) ? 64 : 4;
    endfunction

    function automatic int satMaxOf(input int i);
        return (i == 0) ? 65535 : 7;
    endfunction

    // Expected {pc_we,fd_we,dx_we,fd_flush,dx_flush,xm_bubble,md_done,md_fault}.
    function automatic logic [7:0] modelCtl(input int i);
        bit timed_out;
        if (reset_n !== 1'b1) return 8'h00;
        if (m_md[i]) begin
            timed_out = (m_el[i] == timeoutOf(i));
            if (md_ready || md_exception || timed_out)
                return {6'b111000, 1'b1, (md_exception || timed_out)};
            return 8'b0000_0100;
        end
        if (x_redirect) return 8'b1111_1000;
        if (x_md_start) return 8'b0000_0100;
        if (dx_is_load && dx_rd != 0 &&
            (dx_rd == fd_rs1 || (fd_uses_rs2 && dx_rd == fd_rs2)))
            return 8'b0010_1000;
        return 8'b1110_0000;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_md[i]    = 1'b0;
            m_el[i]    = 0;
            m_stall[i] = 0;
        end
    endtask

    task automatic clearInputs();
        fd_rs1 = 5'd0; fd_rs2 = 5'd0; dx_rd = 5'd0;
        fd_uses_rs2 = 1'b0; dx_is_load = 1'b0; x_redirect = 1'b0;
        x_md_start = 1'b0; md_ready = 1'b0; md_exception = 1'b0; stat_clear = 1'b0;
    endtask

    task automatic sampleCycle();
        @(negedge clock);
        checkOutput("ctl_a", ctl_a, modelCtl(0));
        checkOutput("ctl_b", ctl_b, modelCtl(1));
        checkOutput("stall_a", sc_a, m_stall[0]);
        checkOutput("stall_b", sc_b, m_stall[1]);
    endtask

    task automatic advanceClock();
        logic [7:0] e[2];
        for (int i = 0; i < 2; i++) e[i] = modelCtl(i);
        @(posedge clock);
        for (int i = 0; i < 2; i++) begin
            if (reset_n !== 1'b1) begin
                m_md[i] = 1'b0; m_el[i] = 0; m_stall[i] = 0;
            end else begin
                if (stat_clear) m_stall[i] = 0;
                else if (!e[i][7] && m_stall[i] < satMaxOf(i)) m_stall[i]++;
                if (m_md[i]) begin
                    if (e[i][1]) m_md[i] = 1'b0;
                    else m_el[i]++;
                end else if (x_md_start && !x_redirect) begin
                    m_md[i] = 1'b1;
                    m_el[i] = 1;
                end
            end
        end
        #1;
    endtask

    task automatic runCycle();
        sampleCycle();
        advanceClock();
    endtask

    task automatic applyStimulus();
        reset_n      = ($urandom_range(0, 299) != 0);
        fd_rs1       = 5'($urandom_range(0, 3));
        fd_rs2       = 5'($urandom_range(0, 3));
        dx_rd        = 5'($urandom_range(0, 3));
        fd_uses_rs2  = ($urandom_range(0, 1) == 0);
        dx_is_load   = ($urandom_range(0, 1) == 0);
        x_redirect   = ($urandom_range(0, 9) == 0);
        x_md_start   = ($urandom_range(0, 11) == 0);
        md_ready     = ($urandom_range(0, 5) == 0);
        md_exception = ($urandom_range(0, 19) == 0);
        stat_clear   = ($urandom_range(0, 39) == 0);
        if (!reset_n) modelReset();
    endtask

    initial begin
        clearInputs();
        reset_n = 1'b0;
        modelReset();
        sampleCycle();
        checkOutput("rst_ctl_a", ctl_a, 8'h00);
        checkOutput("rst_cnt_a", sc_a, 0);
        advanceClock();
        reset_n = 1'b1;
        runCycle();

        dx_is_load = 1'b1; dx_rd = 5'd5; fd_rs1 = 5'd5;
        sampleCycle();
        checkOutput("lu_rs1", ctl_a, 8'h28);
        advanceClock();
        clearInputs();
        sampleCycle();
        checkOutput("lu_clear", ctl_a, 8'hE0);
        checkOutput("lu_stall_cnt", sc_a, 1);
        advanceClock();

        dx_is_load = 1'b1; dx_rd = 5'd0; fd_rs1 = 5'd0;
        sampleCycle();
        checkOutput("lu_r0", ctl_a, 8'hE0);
        advanceClock();

        dx_is_load = 1'b1; dx_rd = 5'd7; fd_rs2 = 5'd7; fd_rs1 = 5'd1; fd_uses_rs2 = 1'b0;
        sampleCycle();
        checkOutput("rs2_unused", ctl_a, 8'hE0);
        advanceClock();
        fd_uses_rs2 = 1'b1;
        sampleCycle();
        checkOutput("rs2_used", ctl_a, 8'h28);
        advanceClock();

        x_redirect = 1'b1;
        sampleCycle();
        checkOutput("redir_hz", ctl_a, 8'hF8);
        advanceClock();
        clearInputs();
        sampleCycle();
        checkOutput("redir_stall_cnt", sc_a, 2);
        advanceClock();

        x_md_start = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            if (c == 1) x_md_start = 1'b0;
            if (c == 5) md_ready = 1'b1;
            sampleCycle();
            if (c < 5) checkOutput("md_hold", ctl_a, 8'h04);
            else checkOutput("md_rel", ctl_a, 8'hE2);
            if (c == 4) checkOutput("to_rel_b", ctl_b, 8'hE3);
            if (c == 5) checkOutput("to_run_b", ctl_b, 8'hE0);
            advanceClock();
        end
        clearInputs();
        sampleCycle();
        checkOutput("md_stall_cnt", sc_a, 7);
        advanceClock();

        x_md_start = 1'b1;
        runCycle();
        clearInputs();
        md_ready = 1'b1; md_exception = 1'b1;
        sampleCycle();
        checkOutput("both_rel", ctl_a, 8'hE3);
        advanceClock();
        sampleCycle();
        checkOutput("both_once", ctl_a, 8'hE0);
        advanceClock();

        clearInputs();
        stat_clear = 1'b1;
        runCycle();
        stat_clear = 1'b0;
        dx_is_load = 1'b1; dx_rd = 5'd3; fd_rs1 = 5'd3;
        for (int c = 0; c < 10; c++) runCycle();
        sampleCycle();
        checkOutput("sat_b", sc_b, 7);
        checkOutput("cnt10_a", sc_a, 10);
        advanceClock();
        sampleCycle();
        checkOutput("sat_hold_b", sc_b, 7);
        stat_clear = 1'b1;
        advanceClock();
        clearInputs();
        sampleCycle();
        checkOutput("clr_b", sc_b, 0);
        checkOutput("clr_a", sc_a, 0);
        advanceClock();

        x_md_start = 1'b1;
        runCycle();
        clearInputs();
        sampleCycle();
        checkOutput("pre_rst_wait", ctl_a, 8'h04);
        advanceClock();
        reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_async_ctl", ctl_a, 8'h00);
        checkOutput("rst_async_cnt", sc_a, 0);
        md_ready = 1'b1;
        runCycle();
        reset_n = 1'b1;
        md_ready = 1'b0;
        sampleCycle();
        checkOutput("post_rst_run", ctl_a, 8'hE0);
        advanceClock();

        for (int n = 0; n < 2000; n++) begin
            applyStimulus();
            runCycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
